// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and visible-window bounds.
// The game controller imports the same bounds for its ground limits.
package vga_timing_pkg;

  localparam int unsigned CountW = 10;

  localparam int unsigned ClkDiv    = 4;
  localparam int unsigned HTotal    = 800;
  localparam int unsigned HSync     = 96;
  localparam int unsigned HVisStart = 144;
  localparam int unsigned HVisEnd   = 783;
  localparam int unsigned VTotal    = 525;
  localparam int unsigned VSync     = 2;
  localparam int unsigned VVisStart = 35;
  localparam int unsigned VVisEnd   = 514;
  localparam int unsigned FrameDiv  = 1;

  typedef logic [CountW-1:0] count_t;

  // Inclusive unsigned range test used for the visible window.
  function automatic logic in_range(input count_t x, input count_t lo, input count_t hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Prescaler: counts 0..DIV-1 and emits a registered one-clk enable after each wrap point.
module clk_en_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic en_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("clk_en_div: DIV must be >= 2");
  end

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            en_q, en_d;

  always_comb begin
    en_d  = (cnt_q == CntLast);
    cnt_d = en_d ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

  assign en_o = en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing: h/v counters, registered visible/sync decode and a frame-rate game tick.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = ClkDiv,
  parameter int unsigned H_TOTAL     = HTotal,
  parameter int unsigned H_SYNC      = HSync,
  parameter int unsigned H_VIS_START = HVisStart,
  parameter int unsigned H_VIS_END   = HVisEnd,
  parameter int unsigned V_TOTAL     = VTotal,
  parameter int unsigned V_SYNC      = VSync,
  parameter int unsigned V_VIS_START = VVisStart,
  parameter int unsigned V_VIS_END   = VVisEnd,
  parameter int unsigned FRAME_DIV   = FrameDiv
) (
  input  logic              clk,
  input  logic              rst,
  output logic              pix_en,
  output logic [CountW-1:0] hCount,
  output logic [CountW-1:0] vCount,
  output logic              bright,
  output logic              hSync,
  output logic              vSync,
  output logic              frame_tick,
  output logic              game_tick
);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 2 || V_TOTAL < 2) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must be in 2..1024");
  end
  if (FRAME_DIV < 1 || FRAME_DIV > 15) begin : g_bad_frame_div
    $error("vga_timing_gen: FRAME_DIV must be in 1..15");
  end
  if (H_VIS_END >= H_TOTAL || V_VIS_END + 1 >= V_TOTAL) begin : g_bad_window
    $error("vga_timing_gen: visible window must end inside the frame, before the last line");
  end

  localparam count_t HLast   = count_t'(H_TOTAL - 1);
  localparam count_t VLast   = count_t'(V_TOTAL - 1);
  localparam count_t HSyncC  = count_t'(H_SYNC);
  localparam count_t VSyncC  = count_t'(V_SYNC);
  localparam count_t HVisLo  = count_t'(H_VIS_START);
  localparam count_t HVisHi  = count_t'(H_VIS_END);
  localparam count_t VVisLo  = count_t'(V_VIS_START);
  localparam count_t VVisHi  = count_t'(V_VIS_END);
  localparam count_t VTick   = count_t'(V_VIS_END + 1);
  localparam logic [3:0] DivLast = 4'(FRAME_DIV - 1);

  logic pix_en_w;

  clk_en_div #(
    .DIV (CLK_DIV)
  ) u_pix_div (
    .clk_i (clk),
    .rst_i (rst),
    .en_o  (pix_en_w)
  );

  count_t     h_q, h_d, v_q, v_d;
  count_t     h_next, v_next;
  logic       bright_q, bright_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_tick_q, frame_tick_d;
  logic       game_tick_q, game_tick_d;
  logic [3:0] div_q, div_d;

  always_comb begin
    if (h_q == HLast) begin
      h_next = '0;
      v_next = (v_q == VLast) ? '0 : v_q + count_t'(1);
    end else begin
      h_next = h_q + count_t'(1);
      v_next = v_q;
    end
  end

  // Decode from the next counts so the flags line up with the counts they describe.
  always_comb begin
    h_d          = h_q;
    v_d          = v_q;
    bright_d     = bright_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    frame_tick_d = 1'b0;
    if (pix_en_w) begin
      h_d          = h_next;
      v_d          = v_next;
      bright_d     = in_range(h_next, HVisLo, HVisHi) && in_range(v_next, VVisLo, VVisHi);
      hsync_d      = (h_next >= HSyncC);
      vsync_d      = (v_next >= VSyncC);
      frame_tick_d = (h_next == '0) && (v_next == VTick);
    end
  end

  always_comb begin
    div_d       = div_q;
    game_tick_d = 1'b0;
    if (frame_tick_d) begin
      if (div_q == DivLast) begin
        div_d       = '0;
        game_tick_d = 1'b1;
      end else begin
        div_d = div_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q          <= '0;
      v_q          <= '0;
      bright_q     <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      game_tick_q  <= 1'b0;
      div_q        <= '0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      bright_q     <= bright_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
      game_tick_q  <= game_tick_d;
      div_q        <= div_d;
    end
  end

  assign pix_en     = pix_en_w;
  assign hCount     = h_q;
  assign vCount     = v_q;
  assign bright     = bright_q;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign frame_tick = frame_tick_q;
  assign game_tick  = game_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster so several whole frames fit in the run.
module tb_vga_timing_gen;

  localparam int unsigned D   = 3;
  localparam int unsigned HT  = 24;
  localparam int unsigned HS  = 4;
  localparam int unsigned HVS = 6;
  localparam int unsigned HVE = 19;
  localparam int unsigned VT  = 14;
  localparam int unsigned VS  = 2;
  localparam int unsigned VVS = 3;
  localparam int unsigned VVE = 11;
  localparam int unsigned FD  = 3;
  localparam int unsigned NCYC = 15000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en, bright, hSync, vSync, frame_tick, game_tick;
  logic [9:0] hCount, vCount;

  typedef struct packed {
    logic       pe;
    logic [9:0] h;
    logic [9:0] v;
    logic       br;
    logic       hs;
    logic       vs;
    logic       ft;
    logic       gt;
  } obs_t;

  obs_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned c     = 0;

  vga_timing_gen #(
    .CLK_DIV     (D),
    .H_TOTAL     (HT),
    .H_SYNC      (HS),
    .H_VIS_START (HVS),
    .H_VIS_END   (HVE),
    .V_TOTAL     (VT),
    .V_SYNC      (VS),
    .V_VIS_START (VVS),
    .V_VIS_END   (VVE),
    .FRAME_DIV   (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .hCount     (hCount),
    .vCount     (vCount),
    .bright     (bright),
    .hSync      (hSync),
    .vSync      (vSync),
    .frame_tick (frame_tick),
    .game_tick  (game_tick)
  );

  always #5 clk = ~clk;

  // Reference: everything follows from c, the number of clk edges since reset released.
  function automatic obs_t model(input int unsigned cc);
    obs_t        o;
    int unsigned p, h, v, off, k;
    logic        adv;
    o.pe = (cc >= D) && (cc % D == 0);
    p    = (cc == 0) ? 0 : (cc - 1) / D;      // pixels advanced so far
    adv  = (cc >= D + 1) && ((cc - 1) % D == 0);
    h    = p % HT;
    v    = (p / HT) % VT;
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.br = (h >= HVS) && (h <= HVE) && (v >= VVS) && (v <= VVE);
    o.hs = (h >= HS);
    o.vs = (v >= VS);
    o.ft = adv && (h == 0) && (v == VVE + 1);
    off  = HT * (VVE + 1);
    k    = (p >= off) ? ((p - off) / (HT * VT) + 1) : 0;
    o.gt = o.ft && (k % FD == 0);
    return o;
  endfunction

  // Stimulus: initial reset, then random resets (plus one forced mid-frame).
  initial begin
    int hold;
    hold = 0;
    rst  = 1'b1;
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      if (rst) c = 0;
      else c++;
      exp_q.push_back(model(c));
      #1;
      if (i < 4) begin
        rst = 1'b1;
      end else if (hold > 0) begin
        rst = 1'b1;
        hold--;
      end else if (i == 4000 || $urandom_range(0, 7999) == 0) begin
        rst  = 1'b1;
        hold = int'($urandom_range(0, 2));
      end else begin
        rst = 1'b0;
      end
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: leftover=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        obs_t e;
        obs_t a;
        e = exp_q.pop_front();
        a = {pix_en, hCount, vCount, bright, hSync, vSync, frame_tick, game_tick};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs @%0t: got pe=%b h=%0d v=%0d br=%b hs=%b vs=%b ft=%b gt=%b want pe=%b h=%0d v=%0d br=%b hs=%b vs=%b ft=%b gt=%b",
                   $time, a.pe, a.h, a.v, a.br, a.hs, a.vs, a.ft, a.gt,
                   e.pe, e.h, e.v, e.br, e.hs, e.vs, e.ft, e.gt);
        end
      end
    end
  end

endmodule
